tick_monitor: RTL

- Receive side of the periodic enable-tick scheme: measures clk cycles between rising edges of an incoming tick/pulse signal and checks them against the nominal INPUT_FREQ/TARGET_FREQ period.
- Reports each measured period, flags in-tolerance or out-of-tolerance, and declares lock after a run of good periods.
- Raises a timeout when ticks stop arriving.
- Used to supervise divided-clock enables and external slow references (1PPS-style inputs, board tick inputs).

---
 rtl/tick_monitor.sv | 91 +++++++++
 1 files changed

// File: rtl/tick_monitor.sv
// tick_monitor: measures clk cycles between pulse_in rising edges, checks tolerance, tracks lock and timeout
module tick_monitor #(
  parameter int INPUT_FREQ  = 1_000_000,
  parameter int TARGET_FREQ = 10,
  parameter int TOL         = 100,
  parameter int LOCK_COUNT  = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             in_tol,
  output logic             locked,
  output logic             timeout
);
  localparam int DIV = INPUT_FREQ / TARGET_FREQ;
  localparam logic [CNT_W-1:0] HI = CNT_W'(DIV + TOL);
  localparam logic [CNT_W-1:0] LO = CNT_W'((TOL >= DIV) ? 0 : DIV - TOL);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [GW-1:0] LAST = GW'(LOCK_COUNT - 1);
  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;
  state_t state, state_n;
  logic s1, s2, s3, rise, ok;
  logic [CNT_W-1:0] cnt, period_n;
  logic [GW-1:0] good, good_n;
  logic in_tol_n, locked_n, pv_n, to_n;
  assign rise = s2 & ~s3;
  assign ok = (cnt >= LO) && (cnt <= HI);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {s1, s2, s3} <= '0;
      cnt          <= '0;
      state        <= IDLE;
      good         <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      in_tol       <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      {s1, s2, s3} <= {pulse_in, s1, s2};
      cnt          <= rise ? CNT_W'(1) : cnt + CNT_W'(cnt != '1);
      state        <= state_n;
      good         <= good_n;
      period       <= period_n;
      period_valid <= pv_n;
      in_tol       <= in_tol_n;
      locked       <= locked_n;
      timeout      <= to_n;
    end
  end
  always_comb begin
    state_n  = state;
    good_n   = good;
    period_n = period;
    in_tol_n = in_tol;
    locked_n = locked;
    pv_n     = 1'b0;
    to_n     = 1'b0;
    if (state == IDLE) begin
      if (rise) begin
        state_n = ACQ;
        good_n  = '0;
      end
    end else if (rise) begin
      pv_n     = 1'b1;
      period_n = cnt;
      in_tol_n = ok;
      if (!ok) begin
        good_n   = '0;
        locked_n = 1'b0;
        state_n  = ACQ;
      end else if (state == ACQ) begin
        good_n = good + 1'b1;
        if (good == LAST) begin
          state_n  = LOCKED;
          locked_n = 1'b1;
        end
      end
    end else if (cnt == HI) begin
      // an edge on the HI cycle is a capture, so only an edgeless HI cycle times out
      to_n     = 1'b1;
      locked_n = 1'b0;
      in_tol_n = 1'b0;
      good_n   = '0;
      state_n  = IDLE;
    end
  end
endmodule
